// File: rtl/uart_alu_pkg.sv
// Shared constants, FSM encoding and header helpers for the UART ALU.
package uart_alu_pkg;

  localparam logic [7:0]  OP_ECHO          = 8'hEC;
  localparam logic [7:0]  OP_ADD           = 8'hAD;
  localparam logic [7:0]  OP_MUL           = 8'h88;
  localparam logic [15:0] HDR_BYTES        = 16'd4;
  localparam logic [15:0] PRESCALE_DEFAULT = 16'd35;

  typedef enum logic [2:0] {
    ST_OPCODE,
    ST_RSVD,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_PAYLOAD,
    ST_MUL_BUSY,
    ST_RESULT
  } state_t;

  // Payload byte count from the header length; short lengths mean header only.
  function automatic logic [15:0] payload_len(input logic [15:0] len);
    return (len < HDR_BYTES) ? 16'd0 : len - HDR_BYTES;
  endfunction

endpackage

// File: rtl/uart.sv
// AXI-Stream byte UART, 8N1, LSB first. One bit lasts prescale*8 clocks.
module uart (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  input  logic        rxd,
  output logic        txd,
  output logic        tx_busy,
  output logic        rx_busy,
  output logic        rx_overrun_error,
  output logic        rx_frame_error,
  input  logic [15:0] prescale
);

  logic [18:0] w_bit_len;
  logic [18:0] w_half_len;
  logic        w_rxd;

  logic [1:0]  r_rxd_s;
  logic        r_rx_busy;
  logic [18:0] r_rx_cnt;
  logic [3:0]  r_rx_bit;
  logic [7:0]  r_rx_sh;
  logic [7:0]  r_m_data;
  logic        r_m_valid;
  logic        r_ovr;
  logic        r_ferr;

  logic        r_tx_busy;
  logic [18:0] r_tx_cnt;
  logic [3:0]  r_tx_bit;
  logic [8:0]  r_tx_sh;
  logic        r_txd;

  assign w_bit_len  = {prescale, 3'b000} - 19'd1;
  assign w_half_len = {1'b0, prescale, 2'b00} - 19'd1;
  assign w_rxd      = r_rxd_s[1];

  assign s_axis_tready    = ~r_tx_busy;
  assign m_axis_tdata     = r_m_data;
  assign m_axis_tvalid    = r_m_valid;
  assign txd              = r_txd;
  assign tx_busy          = r_tx_busy;
  assign rx_busy          = r_rx_busy;
  assign rx_overrun_error = r_ovr;
  assign rx_frame_error   = r_ferr;

  // Receiver: synchronise rxd, sample each bit at its centre, check stop bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rxd_s   <= 2'b11;
      r_rx_busy <= 1'b0;
      r_rx_cnt  <= '0;
      r_rx_bit  <= '0;
      r_rx_sh   <= '0;
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
      r_ovr     <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_rxd_s <= {r_rxd_s[0], rxd};
      r_ovr   <= 1'b0;
      r_ferr  <= 1'b0;
      if (r_m_valid && m_axis_tready) r_m_valid <= 1'b0;
      if (!r_rx_busy) begin
        if (!w_rxd) begin
          r_rx_busy <= 1'b1;
          r_rx_cnt  <= w_half_len;
          r_rx_bit  <= '0;
        end
      end else if (r_rx_cnt != '0) begin
        r_rx_cnt <= r_rx_cnt - 19'd1;
      end else if (r_rx_bit == 4'd0) begin
        // Start bit gone high at its centre: treat as a glitch.
        if (w_rxd) r_rx_busy <= 1'b0;
        else begin
          r_rx_bit <= 4'd1;
          r_rx_cnt <= w_bit_len;
        end
      end else if (r_rx_bit != 4'd9) begin
        r_rx_sh  <= {w_rxd, r_rx_sh[7:1]};
        r_rx_bit <= r_rx_bit + 4'd1;
        r_rx_cnt <= w_bit_len;
      end else begin
        r_rx_busy <= 1'b0;
        if (w_rxd) begin
          r_m_data  <= r_rx_sh;
          r_m_valid <= 1'b1;
          r_ovr     <= r_m_valid && !m_axis_tready;
        end else begin
          r_ferr <= 1'b1;
        end
      end
    end
  end

  // Transmitter: start bit, 8 data bits, stop bit, then ready for the next byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_busy <= 1'b0;
      r_tx_cnt  <= '0;
      r_tx_bit  <= '0;
      r_tx_sh   <= '0;
      r_txd     <= 1'b1;
    end else if (!r_tx_busy) begin
      if (s_axis_tvalid) begin
        r_tx_busy <= 1'b1;
        r_txd     <= 1'b0;
        r_tx_sh   <= {1'b1, s_axis_tdata};
        r_tx_bit  <= '0;
        r_tx_cnt  <= w_bit_len;
      end
    end else if (r_tx_cnt != '0) begin
      r_tx_cnt <= r_tx_cnt - 19'd1;
    end else if (r_tx_bit == 4'd9) begin
      r_tx_busy <= 1'b0;
    end else begin
      r_txd    <= r_tx_sh[0];
      r_tx_sh  <= {1'b0, r_tx_sh[8:1]};
      r_tx_bit <= r_tx_bit + 4'd1;
      r_tx_cnt <= w_bit_len;
    end
  end

endmodule

// File: rtl/uart_alu_mul.sv
// Iterative shift-add multiplier, one multiplier bit per clock, low 32 bits kept.
module alu_mul32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_p
);

  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_p;
  logic [5:0]  r_cnt;
  logic        r_busy;
  logic        r_done;

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_p    = r_p;

  // Load operands on start, then 32 add/shift steps; done pulses with the final product.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_p    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start && !r_busy) begin
        r_a    <= i_a;
        r_b    <= i_b;
        r_p    <= '0;
        r_cnt  <= 6'd32;
        r_busy <= 1'b1;
      end else if (r_busy) begin
        if (r_b[0]) r_p <= r_p + r_a;
        r_a   <= {r_a[30:0], 1'b0};
        r_b   <= {1'b0, r_b[31:1]};
        r_cnt <= r_cnt - 6'd1;
        if (r_cnt == 6'd1) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_alu_top.sv
// UART ALU: packet controller around a byte UART; echoes payloads or returns add/mul results.
module uart_alu_top
  import uart_alu_pkg::*;
#(
  parameter logic [15:0] PRESCALE = PRESCALE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_i,
  output logic tx_o
);

  state_t      r_state;
  state_t      w_nxt;

  logic [7:0]  r_op;
  logic [7:0]  r_len_lo;
  logic [15:0] r_cnt;
  logic [31:0] r_opnd;
  logic [1:0]  r_bcnt;
  logic [31:0] r_acc;
  logic        r_have_first;
  logic [7:0]  r_tx_data;
  logic        r_tx_valid;
  logic [1:0]  r_res_idx;

  logic [7:0]  w_rx_data;
  logic        w_rx_valid;
  logic        w_rx_ready;
  logic        w_tx_ready;
  logic        w_tx_busy;
  logic        w_rx_busy;
  logic        w_rx_ovr;
  logic        w_rx_ferr;
  logic        w_rx_fire;
  logic        w_tx_fire;
  logic [15:0] w_pay;
  logic [31:0] w_opnd;
  logic        w_op_done;
  logic        w_is_arith;
  logic        w_mul_start;
  logic        w_mul_busy;
  logic        w_mul_done;
  logic [31:0] w_mul_p;
  logic        w_last;
  logic [1:0]  w_res_nxt;

  uart u_uart (
    .clk              (clk),
    .rst              (rst),
    .s_axis_tdata     (r_tx_data),
    .s_axis_tvalid    (r_tx_valid),
    .s_axis_tready    (w_tx_ready),
    .m_axis_tdata     (w_rx_data),
    .m_axis_tvalid    (w_rx_valid),
    .m_axis_tready    (w_rx_ready),
    .rxd              (rx_i),
    .txd              (tx_o),
    .tx_busy          (w_tx_busy),
    .rx_busy          (w_rx_busy),
    .rx_overrun_error (w_rx_ovr),
    .rx_frame_error   (w_rx_ferr),
    .prescale         (PRESCALE)
  );

  alu_mul32 u_mul (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_mul_start),
    .i_a     (r_acc),
    .i_b     (w_opnd),
    .o_busy  (w_mul_busy),
    .o_done  (w_mul_done),
    .o_p     (w_mul_p)
  );

  // Received bytes stall while multiplying, sending a result, or holding an echo byte.
  assign w_rx_ready  = !(r_state == ST_MUL_BUSY || r_state == ST_RESULT ||
                         r_tx_valid || w_mul_busy);
  assign w_rx_fire   = w_rx_valid && w_rx_ready;
  assign w_tx_fire   = r_tx_valid && w_tx_ready;
  assign w_pay       = payload_len({w_rx_data, r_len_lo});
  assign w_opnd      = {w_rx_data, r_opnd[31:8]};
  assign w_op_done   = w_rx_fire && (r_state == ST_PAYLOAD) && (r_bcnt == 2'd3);
  assign w_is_arith  = (r_op == OP_ADD) || (r_op == OP_MUL);
  assign w_mul_start = w_op_done && (r_op == OP_MUL) && r_have_first;
  assign w_last      = (r_cnt == 16'd1);
  assign w_res_nxt   = r_res_idx + 2'd1;

  // Controller state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_OPCODE;
    else      r_state <= w_nxt;
  end

  // Next-state logic: header walk, payload consumption, multiply wait, result send.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_OPCODE:   if (w_rx_fire) w_nxt = ST_RSVD;
      ST_RSVD:     if (w_rx_fire) w_nxt = ST_LEN_LO;
      ST_LEN_LO:   if (w_rx_fire) w_nxt = ST_LEN_HI;
      ST_LEN_HI: begin
        if (w_rx_fire) begin
          if (w_pay != 16'd0) w_nxt = ST_PAYLOAD;
          else                w_nxt = w_is_arith ? ST_RESULT : ST_OPCODE;
        end
      end
      ST_PAYLOAD: begin
        if (w_rx_fire) begin
          if (w_mul_start) w_nxt = ST_MUL_BUSY;
          else if (w_last) w_nxt = w_is_arith ? ST_RESULT : ST_OPCODE;
        end
      end
      ST_MUL_BUSY: if (w_mul_done) w_nxt = (r_cnt == 16'd0) ? ST_RESULT : ST_PAYLOAD;
      ST_RESULT:   if (w_tx_fire && r_res_idx == 2'd3) w_nxt = ST_OPCODE;
      default:     w_nxt = ST_OPCODE;
    endcase
  end

  // Datapath: header capture, byte counter, operand assembly, accumulator, transmit byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op         <= '0;
      r_len_lo     <= '0;
      r_cnt        <= '0;
      r_opnd       <= '0;
      r_bcnt       <= '0;
      r_acc        <= '0;
      r_have_first <= 1'b0;
      r_tx_data    <= '0;
      r_tx_valid   <= 1'b0;
      r_res_idx    <= '0;
    end else begin
      if (w_tx_fire) r_tx_valid <= 1'b0;
      case (r_state)
        ST_OPCODE: begin
          if (w_rx_fire) begin
            r_op         <= w_rx_data;
            r_acc        <= '0;
            r_bcnt       <= '0;
            r_cnt        <= '0;
            r_have_first <= 1'b0;
          end
        end
        ST_LEN_LO: if (w_rx_fire) r_len_lo <= w_rx_data;
        ST_LEN_HI: if (w_rx_fire) r_cnt <= w_pay;
        ST_PAYLOAD: begin
          if (w_rx_fire) begin
            r_cnt  <= r_cnt - 16'd1;
            r_opnd <= w_opnd;
            r_bcnt <= r_bcnt + 2'd1;
            if (r_op == OP_ECHO) begin
              r_tx_valid <= 1'b1;
              r_tx_data  <= w_rx_data;
            end
            if (w_op_done) begin
              if (r_op == OP_ADD) begin
                r_acc <= r_acc + w_opnd;
              end else if (r_op == OP_MUL && !r_have_first) begin
                r_acc        <= w_opnd;
                r_have_first <= 1'b1;
              end
            end
          end
        end
        ST_MUL_BUSY: if (w_mul_done) r_acc <= w_mul_p;
        ST_RESULT: begin
          // First cycle here has no byte pending; later bytes follow each acceptance.
          if (!r_tx_valid) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= r_acc[7:0];
            r_res_idx  <= '0;
          end else if (w_tx_fire && r_res_idx != 2'd3) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= r_acc[{w_res_nxt, 3'b000} +: 8];
            r_res_idx  <= w_res_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_alu_top.sv
// Bench for uart_alu_top: serial stimulus, serial capture, packet-level reference model.
module tb_uart_alu_top;

  localparam int PS  = 2;
  localparam int BIT = PS * 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx_i = 1'b1;
  logic tx_o;

  int n_chk = 0;
  int n_fail = 0;
  int tx_ferr = 0;
  int rst_epoch = 0;

  logic [7:0] mon_q[$];
  logic [7:0] pkt_q[$];
  logic [7:0] exp_q[$];

  uart_alu_top #(.PRESCALE(16'(PS))) dut (
    .clk  (clk),
    .rst  (rst),
    .rx_i (rx_i),
    .tx_o (tx_o)
  );

  always #5 clk = ~clk;

  always @(negedge rst) rst_epoch++;

  // Serial capture of tx_o; frames cut by a reset are discarded.
  always begin : mon
    logic [7:0] b;
    logic       stp;
    int         ep;
    @(negedge tx_o);
    ep = rst_epoch;
    repeat (BIT / 2) @(negedge clk);
    if (tx_o == 1'b0) begin
      for (int i = 0; i < 8; i++) begin
        repeat (BIT) @(negedge clk);
        b[i] = tx_o;
      end
      repeat (BIT) @(negedge clk);
      stp = tx_o;
      if (ep == rst_epoch && rst) begin
        if (stp) mon_q.push_back(b);
        else     tx_ferr++;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_i = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx_i = 1'b1;
    repeat (2 * BIT) @(negedge clk);
  endtask

  // Reference: walk packets, apply echo/add/mul rules on whole operands.
  function automatic void model();
    int i = 0;
    exp_q.delete();
    while (i + 4 <= pkt_q.size()) begin
      logic [7:0]  op;
      logic [15:0] len;
      int          pay, nops;
      logic [31:0] res, v;
      op   = pkt_q[i];
      len  = {pkt_q[i+3], pkt_q[i+2]};
      pay  = (len < 16'd4) ? 0 : int'(len) - 4;
      nops = pay / 4;
      if (op == 8'hEC) begin
        for (int k = 0; k < pay; k++) exp_q.push_back(pkt_q[i+4+k]);
      end else if (op == 8'hAD || op == 8'h88) begin
        res = (op == 8'hAD) ? 32'd0 : 32'd1;
        for (int o = 0; o < nops; o++) begin
          v = {pkt_q[i+7+4*o], pkt_q[i+6+4*o], pkt_q[i+5+4*o], pkt_q[i+4+4*o]};
          res = (op == 8'hAD) ? res + v : res * v;
        end
        if (op == 8'h88 && nops == 0) res = 32'd0;
        for (int k = 0; k < 4; k++) exp_q.push_back(res[8*k +: 8]);
      end
      i += 4 + pay;
    end
  endfunction

  task automatic add_hdr(input logic [7:0] op, input logic [15:0] len);
    pkt_q.push_back(op);
    pkt_q.push_back(8'($urandom));
    pkt_q.push_back(len[7:0]);
    pkt_q.push_back(len[15:8]);
  endtask

  task automatic add_bytes(input int n);
    for (int k = 0; k < n; k++) pkt_q.push_back(8'($urandom));
  endtask

  // Send pkt_q, wait for the modelled response, then confirm nothing extra follows.
  task automatic run_pkt(input string name);
    int t = 0;
    int n;
    mon_q.delete();
    model();
    foreach (pkt_q[k]) send_byte(pkt_q[k]);
    while (mon_q.size() < exp_q.size() && t < 20000) begin
      @(negedge clk);
      t++;
    end
    repeat (40 * BIT) @(negedge clk);
    n_chk++;
    if (mon_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL %s count: got %0d bytes, expected %0d", name, mon_q.size(), exp_q.size());
    end
    n = (mon_q.size() < exp_q.size()) ? mon_q.size() : exp_q.size();
    for (int k = 0; k < n; k++) begin
      n_chk++;
      if (mon_q[k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL %s byte%0d: got %02h expected %02h", name, k, mon_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_reset();
    int lows = 0;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    n_chk++;
    if (tx_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_tx_in_reset: got %b expected 1", tx_o);
    end
    rst = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      if (tx_o !== 1'b1) lows++;
    end
    n_chk++;
    if (lows != 0 || mon_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_idle: got %0d low cycles %0d bytes, expected 0 and 0", lows, mon_q.size());
    end
  endtask

  task automatic test_echo();
    pkt_q = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43};
    run_pkt("echo");
  endtask

  task automatic test_add();
    pkt_q = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
              8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_pkt("add_wrap");
  endtask

  task automatic test_mul();
    pkt_q = '{8'h88, 8'h00, 8'h0C, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00,
              8'h05, 8'h00, 8'h00, 8'h00};
    run_pkt("mul");
    pkt_q.delete();
    add_hdr(8'h88, 16'd16);
    add_bytes(12);
    run_pkt("mul_chain3");
  endtask

  task automatic test_unknown();
    pkt_q = '{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB,
              8'hEC, 8'h00, 8'h05, 8'h00, 8'h99};
    run_pkt("unknown_then_echo");
  endtask

  task automatic test_boundaries();
    pkt_q = '{8'hAD, 8'h00, 8'h04, 8'h00};
    run_pkt("add_empty");
    pkt_q = '{8'hAD, 8'h37, 8'h02, 8'h00};
    run_pkt("add_short_len");
    pkt_q = '{8'h88, 8'h00, 8'h00, 8'h00};
    run_pkt("mul_empty");
    pkt_q.delete();
    add_hdr(8'hAD, 16'd10);
    add_bytes(6);
    run_pkt("add_partial");
    pkt_q.delete();
    add_hdr(8'h88, 16'd11);
    add_bytes(7);
    run_pkt("mul_partial");
  endtask

  task automatic test_back_to_back();
    pkt_q.delete();
    add_hdr(8'h31, 16'd7);
    add_bytes(3);
    add_hdr(8'hEC, 16'd6);
    add_bytes(2);
    add_hdr(8'h88, 16'd12);
    add_bytes(8);
    run_pkt("back_to_back");
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      int sel, pay;
      logic [7:0] op;
      sel = int'($urandom_range(0, 4));
      pay = int'($urandom_range(0, 10));
      pkt_q.delete();
      case (sel)
        0: op = 8'hEC;
        1: op = 8'hAD;
        2: op = 8'h88;
        default: begin
          op = 8'($urandom);
          while (op == 8'hEC || op == 8'hAD || op == 8'h88) op = 8'($urandom);
        end
      endcase
      if (sel == 4) begin
        add_hdr(8'hAD, 16'($urandom_range(0, 3)));
      end else begin
        add_hdr(op, 16'(pay + 4));
        add_bytes(pay);
      end
      run_pkt($sformatf("random%0d", r));
    end
  endtask

  task automatic test_reset_mid_packet();
    pkt_q = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01};
    foreach (pkt_q[k]) send_byte(pkt_q[k]);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    pkt_q = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h5A};
    run_pkt("reset_mid_packet");
  endtask

  task automatic test_reset_mid_tx();
    int t = 0;
    mon_q.delete();
    pkt_q = '{8'hAD, 8'h00, 8'h04, 8'h00};
    foreach (pkt_q[k]) send_byte(pkt_q[k]);
    while (tx_o === 1'b1 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    n_chk++;
    if (tx_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_tx_start: got tx_o %b, expected a start bit (0)", tx_o);
    end
    repeat (3 * BIT) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    n_chk++;
    if (tx_o !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_tx_async: got tx_o %b before any clock edge, expected 1", tx_o);
    end
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (20 * BIT) @(negedge clk);
    n_chk++;
    if (mon_q.size() != 0) begin
      n_fail++;
      $display("FAIL mid_tx_truncated: got %0d bytes, expected 0", mon_q.size());
    end
    pkt_q = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'hC3};
    run_pkt("after_mid_tx_reset");
  endtask

  initial begin
    test_reset();
    test_echo();
    test_add();
    test_mul();
    test_unknown();
    test_boundaries();
    test_back_to_back();
    test_reset_mid_packet();
    test_reset_mid_tx();
    test_random();
    n_chk++;
    if (tx_ferr != 0) begin
      n_fail++;
      $display("FAIL tx_framing: got %0d bad stop bits, expected 0", tx_ferr);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_alu_top.md
# uart_alu_top

Top-level of the iCE40 UART ALU. Receives byte packets on a 115200-baud 8N1 serial line, decodes a 4-byte header, and either echoes the payload or returns a 32-bit add/multiply result on the serial transmit line. Contains one instance of the codebase `uart` (AXI-Stream byte UART) plus a packet controller FSM and a small arithmetic datapath.

## Interface
Parameters:
- `PRESCALE`, 16'd35: `uart` prescale; clk/(baud·8) at 32.26 MHz (31 ns period) gives 115200 baud.

Ports:
- `clk`  in  1  system clock, 32.26 MHz nominal; the only clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `rx_i`  in  1  serial receive, idle high, 8N1, LSB first.
- `tx_o`  out  1  serial transmit, idle high, 8N1, LSB first.

## Operation
- Packet header, little-endian: byte0 opcode, byte1 reserved (ignored), byte2 length[7:0], byte3 length[15:8]. Length counts the whole packet including header; payload = length−4 bytes. Length < 4 is treated as 4.
- Opcodes:
  - 0xEC echo: each payload byte is retransmitted unchanged, in order.
  - 0xAD add32: payload is 32-bit little-endian operands; result = sum mod 2^32.
  - 0x88 mul32: result = product mod 2^32 (low 32 bits).
  - Any other opcode: consume and discard the payload; send nothing.
- For add32 and mul32, the result is sent as 4 bytes, LSB first, after the last payload byte.
  - Empty payload returns 0x00000000.
  - A trailing partial operand (payload not a multiple of 4) is discarded.
- Accumulation:
  - add starts from 0.
  - mul loads the first operand, then multiplies each later operand in with an iterative shift-add, 1 bit per clock, 32 clocks.
- FSM states and transitions:
  - OPCODE → RSVD → LEN_LO → LEN_HI → PAYLOAD.
  - From LEN_HI: if payload = 0, go to RESULT for add/mul, else OPCODE.
  - PAYLOAD → MUL_BUSY when a mul operand completes; MUL_BUSY → PAYLOAD after 32 clocks.
  - PAYLOAD → RESULT when the last byte is consumed (add/mul); → OPCODE for echo or unknown.
  - RESULT sends 4 bytes, then → OPCODE.
- Flow control: the controller drives `uart` m_axis_tready low while in MUL_BUSY, RESULT, or while an echo byte is waiting for s_axis_tready. Otherwise it accepts received bytes immediately.
- `uart` framing and overrun errors do not change the FSM. A frame-error byte is dropped by `uart` and therefore not counted.
- No inter-packet timeout: a partial packet waits indefinitely until reset.

## Timing
- Reset asserted (low), immediately and asynchronously:
  - FSM in OPCODE, byte counter 0, accumulator 0.
  - s_axis_tvalid 0, m_axis_tready 1.
  - `tx_o` = 1.
- Echo latency: the byte is presented to the `uart` transmit side (s_axis_tvalid) at most 2 clocks after the received byte's m_axis_tvalid handshake.
- Add result: first result byte presented at most 2 clocks after the last payload byte handshake.
- Mul result: first result byte presented at most 35 clocks after the last payload byte handshake.
- Each transmit byte uses an AXI-Stream handshake: tdata is held stable while tvalid=1 && tready=0. The next byte is presented the cycle after acceptance.
- One frame is 10 bits × 8 × 35 = 2800 clocks. A mul step (32 clocks) always finishes before the next operand byte can arrive.
- Reset mid-packet or mid-transmit aborts the operation. `tx_o` returns high at once, and the frame in flight is truncated.

## Structure
- Package `uart_alu_pkg`:
  - opcode constants `OP_ECHO` = 8'hEC, `OP_ADD` = 8'hAD, `OP_MUL` = 8'h88;
  - `HDR_BYTES` = 4;
  - `PRESCALE` default;
  - FSM state enum.
- Sub-modules:
  - `uart`, existing, instantiated once: ports s_axis_*/m_axis_* 8-bit, rxd/txd, busy/error flags, prescale.
  - `alu_mul32`, iterative shift-add multiplier with start/busy/done.
- Top holds the controller FSM, the 16-bit length counter, the operand shift register and the accumulator.

## Test plan
- Reset: hold `rst` low 5 clocks, release → `tx_o` = 1 and no transmission for 10000 clocks.
- Echo: send EC 00 07 00 41 42 43 → receive 41 42 43 in order, then nothing further.
- Add32: send AD 00 0C 00 01 00 00 00 FF FF FF FF → receive 00 00 00 00 (wrap-around).
- Mul32: send 88 00 0C 00 03 00 00 00 05 00 00 00 → receive 0F 00 00 00.
- Unknown opcode: send 55 00 06 00 AA BB, then EC 00 05 00 99 → only 99 is received.
- Empty add: send AD 00 04 00 → receive 00 00 00 00.
- Reset mid-packet: assert `rst` after AD 00 0C 00 01 → next packet EC 00 05 00 5A echoes 5A.
